maze_store: RTL
===============

// Module: maze_store
// PURPOSE
//  Maze storage and loader sitting directly downstream of the maze solver's memory bus (row/col/maze_oe/maze_we -> maze_in).
//  Holds a 2^W x 2^W grid of 2-bit cells, streams in an initial maze from a host, then serves the solver's reads and
//  visited-marks; a host readback port extracts the marked path after the solver raises done.
// PARAMETERS
//  MAZE_WIDTH  6  bits per row/col index; grid is 2^MAZE_WIDTH x 2^MAZE_WIDTH (64x64 default)
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rst          in   1           asynchronous, active-high reset
//  ld_valid     in   1           host load beat valid
//  ld_wall      in   1           load data: 1 = wall, 0 = free; cells arrive row-major from (0,0)
//  ld_ready     out  1           load beat accepted when ld_valid & ld_ready
//  maze_ready   out  1           grid fully loaded; solver may run
//  row, col     in   MAZE_WIDTH  solver cell address
//  maze_oe      in   1           solver read enable (sampled at clock edge)
//  maze_we      in   1           solver write enable: mark cell VISITED
//  maze_in      out  1           1 = addressed cell is a wall
//  rb_en        in   1           host readback enable
//  rb_row,rb_col in  MAZE_WIDTH  host readback address
//  rb_data      out  2           cell code of readback address
// BEHAVIOUR
//  - Reset: ld_ready=0, maze_ready=0, maze_in=0, rb_data=0, load counter=0, FSM->IDLE; grid contents undefined until loaded.
//  - Cell codes: FREE=2'b00, WALL=2'b01, VISITED=2'b10; 2'b11 never written.
//  - FSM IDLE -> LOAD on first clock after reset release; LOAD: ld_ready=1, each accepted beat writes cell[cnt] and cnt++.
//    cnt is 2*MAZE_WIDTH bits ({row,col}); accepting the beat at cnt = all-ones -> RUN next cycle (cnt wraps to 0, ld_ready=0).
//  - RUN: maze_ready=1, stays in RUN until reset; further ld_valid ignored (ld_ready=0).
//  - Read: maze_oe=1 at edge k -> maze_in = (cell[row][col]==WALL), valid from edge k until the next oe edge (registered, held).
//    VISITED reads as 0 (not a wall). maze_oe=0 -> maze_in holds its last value.
//  - Write: maze_we=1 at edge in RUN -> cell[row][col] <= VISITED unless it is WALL (walls never overwritten).
//  - oe and we in the same cycle, same address: maze_in returns the pre-write value (read-before-write).
//  - maze_oe/maze_we in IDLE/LOAD: ignored, no grid change; maze_in forced to 1 so a premature solver sees walls.
//  - Readback: rb_en=1 at edge -> rb_data = cell[rb_row][rb_col] next cycle; legal in any state; a same-edge solver write
//    to that cell is not yet visible (old value returned). rb_en=0 -> rb_data holds.
//  - Reset mid-load: FSM back to IDLE, cnt=0; the host restarts the stream from (0,0).
// CONFIGURATION
//  VISIT_COUNT_EN defined: extra output visit_count [2*MAZE_WIDTH:0], reset 0, incremented once per FREE->VISITED transition
//    (re-marking an already VISITED cell does not count); saturates at all-ones. Cleared on reset only.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package maze_pkg: cell_t codes (CELL_FREE/CELL_WALL/CELL_VISITED), store_state_t {ST_IDLE,ST_LOAD,ST_RUN}.
//  - One sub-module maze_cell_ram: 2-bit x 2^(2W) array, one write port (load or mark, muxed by state) plus two
//    registered read ports (solver, readback); the top holds the FSM, counter, wall-protect and optional visit counter.
// TESTING
//  1. Reset, then stream 4096 beats, all free except (5,7) wall -> ld_ready drops and maze_ready=1 the cycle after beat 4096.
//  2. RUN: oe at (5,7) -> maze_in=1 next cycle; oe at (5,8) -> maze_in=0; oe=0 for 3 cycles -> maze_in stays 0.
//  3. we at (5,8) then rb_en at (5,8) -> rb_data=2'b10; we at (5,7) -> rb_data at (5,7) stays 2'b01.
//  4. oe+we same cycle at free (2,2) -> maze_in=0 and rb of (2,2) afterwards returns 2'b10.
//  5. Assert rst after 100 load beats -> maze_ready=0, ld_ready=0 then 1; full reload of 4096 beats reaches RUN.
//  6. VISIT_COUNT_EN: we at (1,1) twice, (1,2) once, wall (5,7) once -> visit_count=2.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared types for the maze store.
//   cell_t        : 2-bit cell code held in the grid
//   store_state_t : loader/run FSM states
package maze_pkg;

  typedef enum logic [1:0] {
    CELL_FREE    = 2'b00,
    CELL_WALL    = 2'b01,
    CELL_VISITED = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } store_state_t;

endpackage

// File: rtl/maze_cell_ram.sv
// maze_cell_ram: 2-bit x 2^AW cell array.
// Ports:
//   clk, rst              clock; asynchronous reset (read registers only)
//   i_wr_en/addr/data     single write port (loader or solver mark)
//   o_wr_old              current content at i_wr_addr, used for wall protect
//                         and FREE->VISITED detection before the write lands
//   i_sol_en/addr, o_sol_data  registered solver read port (holds when idle)
//   i_rb_en/addr,  o_rb_data   registered host readback port (holds when idle)
// Both read ports sample the array before a same-edge write, so they return
// the pre-write value.
module maze_cell_ram
  import maze_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  cell_t         i_wr_data,
  output cell_t         o_wr_old,
  input  logic          i_sol_en,
  input  logic [AW-1:0] i_sol_addr,
  output cell_t         o_sol_data,
  input  logic          i_rb_en,
  input  logic [AW-1:0] i_rb_addr,
  output cell_t         o_rb_data
);

  localparam int DEPTH = 1 << AW;

  logic [1:0] r_mem [0:DEPTH-1];
  logic [1:0] r_sol_data;
  logic [1:0] r_rb_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sol_data <= 2'b00;
      r_rb_data  <= 2'b00;
    end else begin
      if (i_sol_en) begin
        r_sol_data <= r_mem[i_sol_addr];
      end
      if (i_rb_en) begin
        r_rb_data <= r_mem[i_rb_addr];
      end
    end
  end

  assign o_wr_old   = cell_t'(r_mem[i_wr_addr]);
  assign o_sol_data = cell_t'(r_sol_data);
  assign o_rb_data  = cell_t'(r_rb_data);

endmodule

// File: rtl/maze_store.sv
// maze_store: maze grid storage with host loader, solver port and readback.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   ld_valid/ld_wall/ld_ready  row-major load stream starting at (0,0)
//   maze_ready               grid fully loaded, solver may run
//   row/col/maze_oe/maze_we  solver access; maze_in = 1 when cell is a wall
//   rb_en/rb_row/rb_col/rb_data  host readback of raw cell code
//   visit_count              (only with VISIT_COUNT_EN) saturating count of
//                            FREE->VISITED transitions
// Optional feature macro: VISIT_COUNT_EN
module maze_store
  import maze_pkg::*;
#(
  parameter int MAZE_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic                  ld_wall,
  output logic                  ld_ready,
  output logic                  maze_ready,
  input  logic [MAZE_WIDTH-1:0] row,
  input  logic [MAZE_WIDTH-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  rb_en,
  input  logic [MAZE_WIDTH-1:0] rb_row,
  input  logic [MAZE_WIDTH-1:0] rb_col,
`ifdef VISIT_COUNT_EN
  output logic [1:0]            rb_data,
  output logic [2*MAZE_WIDTH:0] visit_count
`else
  output logic [1:0]            rb_data
`endif
);

  localparam int AW = 2 * MAZE_WIDTH;

  store_state_t  r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ld_ready;
  logic          r_maze_ready;
  // r_sel_ram: maze_in comes from the solver read register once RUN has
  // seen an oe; before that it shows r_wall_hold (0 out of reset, 1 while
  // loading so a premature solver sees walls everywhere).
  logic          r_sel_ram;
  logic          r_wall_hold;

  logic          w_run;
  logic          w_load_beat;
  logic          w_mark;
  logic          w_wr_en;
  logic [AW-1:0] w_sol_addr;
  logic [AW-1:0] w_wr_addr;
  cell_t         w_wr_data;
  cell_t         w_wr_old;
  cell_t         w_sol_cell;
  cell_t         w_rb_cell;

  assign w_run       = (r_state == ST_RUN);
  assign w_load_beat = (r_state == ST_LOAD) && ld_valid && r_ld_ready;
  assign w_sol_addr  = {row, col};
  // Walls are never overwritten by a solver mark.
  assign w_mark      = w_run && maze_we && (w_wr_old != CELL_WALL);
  assign w_wr_en     = w_load_beat || w_mark;
  assign w_wr_addr   = w_run ? w_sol_addr : r_cnt;
  assign w_wr_data   = w_run ? CELL_VISITED : (ld_wall ? CELL_WALL : CELL_FREE);

  maze_cell_ram #(.AW(AW)) u_ram (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (w_wr_data),
    .o_wr_old   (w_wr_old),
    .i_sol_en   (w_run && maze_oe),
    .i_sol_addr (w_sol_addr),
    .o_sol_data (w_sol_cell),
    .i_rb_en    (rb_en),
    .i_rb_addr  ({rb_row, rb_col}),
    .o_rb_data  (w_rb_cell)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ld_ready   <= 1'b0;
      r_maze_ready <= 1'b0;
      r_sel_ram    <= 1'b0;
      r_wall_hold  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_LOAD;
          r_ld_ready  <= 1'b1;
          r_wall_hold <= 1'b1;
          r_sel_ram   <= 1'b0;
        end
        ST_LOAD: begin
          r_wall_hold <= 1'b1;
          r_sel_ram   <= 1'b0;
          if (w_load_beat) begin
            r_cnt <= r_cnt + 1'b1;
            // Last cell accepted: counter wraps to 0 and the grid goes live.
            if (r_cnt == '1) begin
              r_state      <= ST_RUN;
              r_ld_ready   <= 1'b0;
              r_maze_ready <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (maze_oe) begin
            r_sel_ram <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ld_ready   = r_ld_ready;
  assign maze_ready = r_maze_ready;
  assign maze_in    = r_sel_ram ? (w_sol_cell == CELL_WALL) : r_wall_hold;
  assign rb_data    = w_rb_cell;

`ifdef VISIT_COUNT_EN
  logic [AW:0] r_visit_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_visit_count <= '0;
    end else if (w_mark && (w_wr_old == CELL_FREE) && (r_visit_count != '1)) begin
      r_visit_count <= r_visit_count + 1'b1;
    end
  end

  assign visit_count = r_visit_count;
`endif

endmodule
